uart_pwm_ctrl: RTL and testbench

UART_PWM_CTRL -- requirements
Module: uart_pwm_ctrl

---
 rtl/uart_pwm_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_pwm_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_pwm_ctrl.sv
// uart_pwm_ctrl: UART-programmed multi-channel PWM generator (frames A5, ch, duty)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rs232_rx   UART serial input, idle high, asynchronous to clk
//   pwm_out    one registered PWM output per channel
//   led        index of the last channel successfully written
//   frame_ok   one-cycle pulse when a valid frame is accepted
//   frame_err  one-cycle pulse when a frame is dropped
`timescale 1ns/1ps
module uart_pwm_ctrl #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600,
    parameter int CH_N   = 4,
    parameter int PWM_W  = 8,
    parameter int PRESC  = 195
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rs232_rx,
    output logic [CH_N-1:0] pwm_out,
    output logic [3:0]      led,
    output logic            frame_ok,
    output logic            frame_err
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int BW       = $clog2(BAUD_DIV + 1);
    localparam int PSW      = PRESC > 1 ? $clog2(PRESC) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CH} p_st_t;

    logic [1:0]       sync;
    logic             rx_s, rx_prev;
    rx_st_t           rx_st;
    logic [BW-1:0]    bcnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg, rx_byte;
    logic             rx_done, rx_err;
    p_st_t            p_st;
    logic [3:0]       ch_q;
    logic [PWM_W-1:0] shadow [CH_N];
    logic [PWM_W-1:0] active [CH_N];
    logic [PSW-1:0]   presc;
    logic [PWM_W-1:0] cnt;
    logic             step;

    assign rx_s = sync[1];
    assign step = presc == PSW'(PRESC - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rs232_rx};

    // Receiver: falling edge starts a byte, mid-bit re-check rejects glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            bcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_byte <= '0;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            case (rx_st)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_st <= RX_START;
                    bcnt  <= '0;
                end
                RX_START: if (bcnt == BW'(HALF - 1)) begin
                    bcnt    <= '0;
                    bit_idx <= '0;
                    rx_st   <= rx_s ? RX_IDLE : RX_DATA;
                end else bcnt <= bcnt + 1'b1;
                RX_DATA: if (bcnt == BW'(BAUD_DIV - 1)) begin
                    bcnt    <= '0;
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_st <= RX_STOP;
                end else bcnt <= bcnt + 1'b1;
                RX_STOP: if (bcnt == BW'(BAUD_DIV - 1)) begin
                    bcnt  <= '0;
                    rx_st <= RX_IDLE;
                    if (rx_s) begin
                        rx_done <= 1'b1;
                        rx_byte <= shreg;
                    end else rx_err <= 1'b1;
                end else bcnt <= bcnt + 1'b1;
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Frame parser: A5, channel, duty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_st      <= IDLE;
            ch_q      <= '0;
            led       <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < CH_N; i++) shadow[i] <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                p_st      <= IDLE;
            end else if (rx_done) begin
                case (p_st)
                    IDLE: if (rx_byte == 8'hA5) p_st <= GOT_HDR;
                    GOT_HDR: if (rx_byte < 8'(CH_N)) begin
                        ch_q <= rx_byte[3:0];
                        p_st <= GOT_CH;
                    end else begin
                        frame_err <= 1'b1;
                        p_st      <= IDLE;
                    end
                    GOT_CH: begin
                        for (int i = 0; i < CH_N; i++)
                            if (ch_q == 4'(i)) shadow[i] <= rx_byte[7 -: PWM_W];
                        frame_ok <= 1'b1;
                        led      <= ch_q;
                        p_st     <= IDLE;
                    end
                    default: p_st <= IDLE;
                endcase
            end
        end
    end

    // PWM: active duties reload only as cnt wraps, so a period never changes mid-way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            cnt     <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CH_N; i++) active[i] <= '0;
        end else begin
            presc <= step ? '0 : presc + 1'b1;
            if (step) cnt <= cnt + 1'b1;
            for (int i = 0; i < CH_N; i++) begin
                if (step && cnt == '1) active[i] <= shadow[i];
                pwm_out[i] <= cnt < active[i];
            end
        end
    end
endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// tb_uart_pwm_ctrl: randomized self-checking bench with a period-level PWM model
`timescale 1ns/1ps
module tb_uart_pwm_ctrl;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 2_500_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int CH_N   = 4;
    localparam int PWM_W  = 8;
    localparam int PRESC  = 8;
    localparam int PER    = 256 * PRESC;

    logic            clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic [CH_N-1:0] pwm_out;
    logic [3:0]      led;
    logic            frame_ok, frame_err;

    int checks = 0, failures = 0;
    int n = 0, wraps = 0, last_wrap = -100000;
    int ok_cnt = 0, err_cnt = 0, led_m = 0;
    int shadow_m [CH_N];
    int active_m [CH_N];
    bit unsure [CH_N];

    uart_pwm_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CH_N(CH_N), .PWM_W(PWM_W), .PRESC(PRESC)) dut (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rx),
        .pwm_out(pwm_out), .led(led), .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // n = rising edges since reset release; counter value after edge k is (k/PRESC)%256
    always @(negedge clk) begin
        logic [CH_N-1:0] e_pwm, mask;
        if (!rst_n) begin
            n = 0;
            last_wrap = -100000;
            for (int i = 0; i < CH_N; i++) begin active_m[i] = 0; unsure[i] = 0; end
            checks++;
            if ({pwm_out, led, frame_ok, frame_err} !== '0) begin
                failures++;
                $display("FAIL reset_outputs pwm=%b led=%0d ok=%b err=%b, need all 0", pwm_out, led, frame_ok, frame_err);
            end
        end else begin
            n++;
            ok_cnt += int'(frame_ok);
            err_cnt += int'(frame_err);
            for (int i = 0; i < CH_N; i++) begin
                e_pwm[i] = (((n - 1) / PRESC) % 256) < active_m[i];
                mask[i]  = !unsure[i];
            end
            checks++;
            if ((pwm_out & mask) !== (e_pwm & mask)) begin
                failures++;
                $display("FAIL pwm_cycle n=%0d got=%b need=%b mask=%b", n, pwm_out, e_pwm, mask);
            end
            if (n % PER == 0) begin
                for (int i = 0; i < CH_N; i++) begin active_m[i] = shadow_m[i]; unsure[i] = 0; end
                last_wrap = n;
                wraps++;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            failures++;
            $display("FAIL %s got=%0d need=%0d", name, got, need);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin rx = b[i]; tick(DIV); end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
        if (!stop) tick(DIV);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic dstop, input int e_ok, input int e_err);
        int ok0 = ok_cnt, err0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, dstop);
        if (e_ok != 0) begin
            shadow_m[int'(c)] = int'(d);
            led_m = int'(c);
            if (n - last_wrap <= DIV + 4) unsure[int'(c)] = 1;
        end
        tick(DIV);
        check("frame_ok_pulses", ok_cnt - ok0, e_ok);
        check("frame_err_pulses", err_cnt - err0, e_err);
        check("led", int'(led), led_m);
    endtask

    task automatic wait_wrap();
        int w0 = wraps, k = 0;
        while (wraps == w0 && k < PER + 10) begin @(posedge clk); k++; end
        check("wrap_seen", int'(wraps != w0), 1);
    endtask

    task automatic measure(input int ch, input int need, input string name);
        int hi = 0;
        wait_wrap();
        repeat (PER) begin @(negedge clk); hi += int'(pwm_out[ch]); end
        check(name, hi, need);
    endtask

    initial begin
        int ok0, err0, kind;
        logic [7:0] c, d;
        for (int i = 0; i < CH_N; i++) shadow_m[i] = 0;
        tick(5);
        #1 rst_n = 1'b1;
        tick(DIV);
        frame(8'h02, 8'h80, 1'b1, 1, 0);
        measure(2, 128 * PRESC, "ch2_high_0x80");
        frame(8'h05, 8'h40, 1'b1, 0, 1);
        frame(8'h00, 8'hFF, 1'b1, 1, 0);
        measure(0, 255 * PRESC, "ch0_high_0xFF");
        frame(8'h01, 8'h33, 1'b0, 0, 1);
        ok0 = ok_cnt; err0 = err_cnt;
        rx = 1'b0;
        tick(DIV / 2 - 4);
        rx = 1'b1;
        tick(3 * DIV);
        check("glitch_ok", ok_cnt - ok0, 0);
        check("glitch_err", err_cnt - err0, 0);
        wait_wrap();
        frame(8'h03, 8'h20, 1'b1, 1, 0);
        frame(8'h03, 8'hC0, 1'b1, 1, 0);
        measure(3, 192 * PRESC, "ch3_last_write_wins");
        for (int it = 0; it < 14; it++) begin
            kind = $urandom_range(0, 3);
            d = 8'($urandom_range(0, 255));
            if (kind == 0) frame(8'($urandom_range(0, 3)), d, 1'b1, 1, 0);
            else if (kind == 1) frame(8'($urandom_range(4, 255)), d == 8'hA5 ? 8'h5A : d, 1'b1, 0, 1);
            else if (kind == 2) frame(8'($urandom_range(0, 3)), d, 1'b0, 0, 1);
            else begin
                ok0 = ok_cnt; err0 = err_cnt;
                send_byte(d == 8'hA5 ? 8'h5A : d, 1'b1);
                tick(DIV);
                check("junk_ok", ok_cnt - ok0, 0);
                check("junk_err", err_cnt - err0, 0);
            end
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        c = 8'h77;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin rx = c[i]; tick(DIV); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        rx = 1'b1;
        for (int i = 0; i < CH_N; i++) shadow_m[i] = 0;
        led_m = 0;
        tick(10);
        #1 rst_n = 1'b1;
        tick(DIV);
        frame(8'h01, 8'h10, 1'b1, 1, 0);
        measure(1, 16 * PRESC, "ch1_high_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
